// File: rtl/jedro_1_muldiv_pkg.sv
// -----------------------------------------------------------------------------
// jedro_1_muldiv_pkg
// Shared types and helpers for the jedro_1 iterative multiply/divide unit.
//   muldiv_op_e : RV32M operation, encoded as the instruction's funct3.
//   state_e     : control FSM states of the unit.
//   is_div / is_rem / is_signed_a / is_signed_b : operation decode helpers.
// -----------------------------------------------------------------------------
package jedro_1_muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } muldiv_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Divide family (DIV, DIVU, REM, REMU).
  function automatic logic is_div(input muldiv_op_e op);
    return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
  endfunction

  // Remainder-returning operations.
  function automatic logic is_rem(input muldiv_op_e op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

  // rs1 is interpreted as signed. MUL is deliberately excluded: the low word
  // of the product does not depend on operand signedness.
  function automatic logic is_signed_a(input muldiv_op_e op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  // rs2 is interpreted as signed.
  function automatic logic is_signed_b(input muldiv_op_e op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/jedro_1_muldiv_negate.sv
// -----------------------------------------------------------------------------
// jedro_1_muldiv_negate
// Combinational conditional two's-complement negation.
//   data_i : value to (optionally) negate, WIDTH bits
//   neg_i  : 1 = output -data_i, 0 = output data_i
//   data_o : result, WIDTH bits (modulo 2^WIDTH)
// -----------------------------------------------------------------------------
module jedro_1_muldiv_negate #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic             neg_i,
  output logic [WIDTH-1:0] data_o
);

  // Invert-and-increment when negation is requested, else pass through.
  always_comb begin
    if (neg_i) begin
      data_o = ~data_i + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      data_o = data_i;
    end
  end

endmodule

// File: rtl/jedro_1_muldiv.sv
// -----------------------------------------------------------------------------
// jedro_1_muldiv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and
// restoring divide, one bit per cycle, one operation in flight.
//   clk_i    : clock, rising edge
//   rst_i    : asynchronous active-high reset (aborts any operation)
//   op_i     : muldiv_op_e operation code (funct3 encoding)
//   a_i/b_i  : rs1 / rs2 operands, captured on acceptance
//   valid_i  : request valid          ready_o : unit idle, request accepted
//   result_o : registered result      valid_o : result valid
//   ready_i  : consumer takes result
// -----------------------------------------------------------------------------
module jedro_1_muldiv
  import jedro_1_muldiv_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [2:0]            op_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic                  valid_o,
  input  logic                  ready_i
);

  localparam int W     = DATA_WIDTH;
  localparam int CNT_W = $clog2(DATA_WIDTH);

  localparam logic [W-1:0]     ZERO_W    = {W{1'b0}};
  localparam logic [W-1:0]     ALL_ONES  = {W{1'b1}};
  localparam logic [W-1:0]     MOST_NEG  = {1'b1, {(W-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  // Architectural state.
  state_e           state_q, state_d;
  muldiv_op_e       op_q, op_d;
  logic [W-1:0]     b_q, b_d;          // divisor / multiplicand magnitude
  logic [2*W-1:0]   acc_q, acc_d;      // mul: {partial hi, multiplier}, div: {remainder, quotient}
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             neg_q, neg_d;      // product / quotient sign
  logic             neg_rem_q, neg_rem_d;
  logic [W-1:0]     result_q, result_d;
  logic             valid_q, valid_d;
  logic             ready_q, ready_d;

  // Request decode.
  muldiv_op_e   req_op_s;
  logic         sign_a_s, sign_b_s;
  logic [W-1:0] a_mag_s, b_mag_s;
  logic         div_by_zero_s, div_overflow_s;

  // Iteration datapath.
  logic [W:0]   mul_sum_s;
  logic [W:0]   div_part_s;
  logic [W:0]   div_diff_s;

  // Fix-up datapath.
  logic [2*W-1:0] prod_fix_s;
  logic [W-1:0]   quot_fix_s, rem_fix_s;
  logic [W-1:0]   fix_result_s;

  assign req_op_s = muldiv_op_e'(op_i);
  assign sign_a_s = is_signed_a(req_op_s) & a_i[W-1];
  assign sign_b_s = is_signed_b(req_op_s) & b_i[W-1];

  assign div_by_zero_s  = is_div(req_op_s) && (b_i == ZERO_W);
  assign div_overflow_s = is_div(req_op_s) && is_signed_b(req_op_s)
                          && (a_i == MOST_NEG) && (b_i == ALL_ONES);

  // Operand magnitudes; the most negative value maps onto itself, which is the
  // correct unsigned magnitude.
  jedro_1_muldiv_negate #(.WIDTH(W)) u_neg_a (
    .data_i(a_i), .neg_i(sign_a_s), .data_o(a_mag_s)
  );
  jedro_1_muldiv_negate #(.WIDTH(W)) u_neg_b (
    .data_i(b_i), .neg_i(sign_b_s), .data_o(b_mag_s)
  );

  // Result sign restoration.
  jedro_1_muldiv_negate #(.WIDTH(2*W)) u_neg_prod (
    .data_i(acc_q), .neg_i(neg_q), .data_o(prod_fix_s)
  );
  jedro_1_muldiv_negate #(.WIDTH(W)) u_neg_quot (
    .data_i(acc_q[W-1:0]), .neg_i(neg_q), .data_o(quot_fix_s)
  );
  jedro_1_muldiv_negate #(.WIDTH(W)) u_neg_rem (
    .data_i(acc_q[2*W-1:W]), .neg_i(neg_rem_q), .data_o(rem_fix_s)
  );

  // Shift-add step: add multiplicand to the high half when the current
  // multiplier LSB is set, then shift the whole accumulator right.
  assign mul_sum_s = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, b_q} : {(W+1){1'b0}});

  // Restoring step: bring the next dividend bit into the partial remainder and
  // trial-subtract the divisor. The partial remainder is always below 2*b so
  // W+1 bits are enough.
  assign div_part_s = {acc_q[2*W-1:W], acc_q[W-1]};
  assign div_diff_s = div_part_s - {1'b0, b_q};

  // Select the architected half/word once the iteration has finished.
  always_comb begin
    fix_result_s = ZERO_W;
    if (is_div(op_q)) begin
      if (is_rem(op_q)) begin
        fix_result_s = rem_fix_s;
      end else begin
        fix_result_s = quot_fix_s;
      end
    end else begin
      if (op_q == OP_MUL) begin
        fix_result_s = prod_fix_s[W-1:0];
      end else begin
        fix_result_s = prod_fix_s[2*W-1:W];
      end
    end
  end

  // Control FSM and next-state datapath.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    b_d        = b_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    neg_d      = neg_q;
    neg_rem_d  = neg_rem_q;
    result_d   = result_q;
    valid_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (valid_i) begin
          op_d      = req_op_s;
          b_d       = b_mag_s;
          acc_d     = {ZERO_W, a_mag_s};
          cnt_d     = CNT_ZERO;
          neg_d     = sign_a_s ^ sign_b_s;
          neg_rem_d = sign_a_s;
          if (div_by_zero_s) begin
            result_d = is_rem(req_op_s) ? a_i : ALL_ONES;
            state_d  = ST_DONE;
          end else if (div_overflow_s) begin
            result_d = is_rem(req_op_s) ? ZERO_W : a_i;
            state_d  = ST_DONE;
          end else begin
            state_d  = ST_CALC;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_CALC: begin
        if (is_div(op_q)) begin
          if (!div_diff_s[W]) begin
            acc_d = {div_diff_s[W-1:0], acc_q[W-2:0], 1'b1};
          end else begin
            acc_d = {div_part_s[W-1:0], acc_q[W-2:0], 1'b0};
          end
        end else begin
          acc_d = {mul_sum_s, acc_q[W-1:1]};
        end
        if (cnt_q == CNT_LAST) begin
          cnt_d   = CNT_ZERO;
          state_d = ST_FIX;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
          state_d = ST_CALC;
        end
      end

      ST_FIX: begin
        result_d = fix_result_s;
        state_d  = ST_DONE;
      end

      ST_DONE: begin
        // valid_o rises one cycle after entering DONE; only a handshake with
        // valid_o already high releases the unit.
        if (valid_q && ready_i) begin
          valid_d = 1'b0;
          state_d = ST_IDLE;
        end else begin
          valid_d = 1'b1;
          state_d = ST_DONE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    ready_d = (state_d == ST_IDLE);
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_MUL;
      b_q       <= ZERO_W;
      acc_q     <= {(2*W){1'b0}};
      cnt_q     <= CNT_ZERO;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= ZERO_W;
      valid_q   <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
      valid_q   <= valid_d;
      ready_q   <= ready_d;
    end
  end

  assign ready_o  = ready_q;
  assign valid_o  = valid_q;
  assign result_o = result_q;

endmodule
